// File: rtl/mult_div_e_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, latencies.
// Division support is controlled by the MD_DIV_EN macro.
package mult_div_e_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_e_if.sv
// Bundle between the pipeline (master) and the multiply/divide unit (slave).
interface mult_div_e_if;

    logic        start;
    logic [1:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b, mthi, mtlo, wdata,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b, mthi, mtlo, wdata,
        output busy, hi, lo
    );

endinterface

// File: rtl/mult_div_e_md_calc.sv
// Combinational result datapath: 64-bit {hi,lo} result and a divide-by-zero flag.
// The divider exists only when MD_DIV_EN is defined.
module md_calc
    import mult_div_e_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Sign-extended operands give the exact signed product in the low 64 bits.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MD_DIV_EN
    logic        sgn;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvsr;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] quot;
    logic [31:0] rem;

    // Magnitude divide, then restore signs: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        sgn   = (op == MD_DIV);
        mag_a = (sgn && a[31]) ? (32'd0 - a) : a;
        mag_b = (sgn && b[31]) ? (32'd0 - b) : b;
        dvsr  = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q_u   = mag_a / dvsr;
        r_u   = mag_a % dvsr;
        quot  = (sgn && (a[31] ^ b[31])) ? (32'd0 - q_u) : q_u;
        rem   = (sgn && a[31]) ? (32'd0 - r_u) : r_u;
    end
`endif

    // Select the result for the latched operation.
    always_comb begin
        result   = 64'd0;
        div_zero = 1'b0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
`ifdef MD_DIV_EN
            MD_DIV, MD_DIVU: begin
                result   = {rem, quot};
                div_zero = (b == 32'd0);
            end
`endif
            default: begin
                result   = 64'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_e.sv
// HI/LO multiply/divide unit: IDLE/RUN sequencer with a latency down-counter and HI/LO registers.
// Division (div/divu) is built only when MD_DIV_EN is defined; otherwise those starts are ignored.
module mult_div_e
    import mult_div_e_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mult_div_e_if.slave md
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic [63:0] calc_res;
    logic        calc_dz;
    logic        op_ok;

    md_calc u_calc (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .result   (calc_res),
        .div_zero (calc_dz)
    );

`ifdef MD_DIV_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = !is_div_op(md.md_op);
`endif

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

    // Next-state logic: a start in IDLE outranks mthi/mtlo; inputs are ignored while running.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (md.start) begin
                    if (op_ok) begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        op_d    = md.md_op;
                        a_d     = md.src_a;
                        b_d     = md.src_b;
                        cnt_d   = is_div_op(md.md_op) ? DIV_LAT : MUL_LAT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (md.mthi) begin
                        hi_d = md.wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (md.mtlo) begin
                        lo_d = md.wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                    // A zero divisor burns the full latency but leaves HI/LO intact.
                    if (!calc_dz) begin
                        hi_d = calc_res[63:32];
                        lo_d = calc_res[31:0];
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and architectural registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= MD_MULT;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

endmodule
